led_blink_ctrl: RTL and testbench
=================================

LED_BLINK_CTRL -- requirements
Module: led_blink_ctrl

Interface
REQ-001 The block SHALL provide the following parameters:
- N_CH, default 4: number of independent LED channels (1..16).
- CNT_W, default 32: width of the period counter and period registers.
- DEF_PERIOD, default 100000000: reset value of every channel period register.
- BURST, default 3: number of full on/off cycles in burst mode (1..255).

REQ-002 The block SHALL provide the following ports:
- clk  in  1: single clock; all logic on posedge.
- rst  in  1: synchronous reset, active-high.
- mode  in  2*N_CH: per-channel mode; bits [2i+1:2i] control channel i; 00 off, 01 on, 10 blink, 11 burst.
- cfg_we  in  1: period write strobe, one cycle.
- cfg_ch  in  4: channel index for the period write.
- cfg_period  in  CNT_W: period value to write.
- o_led  out  N_CH: LED drive, registered.
- o_done  out  N_CH: per-channel burst-complete flag, registered.
- sync_req  in  1: present only with LED_SYNC_EN (REQ-019).

Function
REQ-003 Each channel SHALL contain the following registers: period P[CNT_W-1:0], counter C[CNT_W-1:0], burst toggle count T[8:0], previous mode M[1:0].

REQ-004 Blink mode (10):
- C increments by 1 each cycle.
- When C == P, o_led[i] SHALL toggle and C SHALL wrap to 0 in the same cycle.
- Toggle interval is therefore exactly P+1 cycles.
- Full LED period is 2*(P+1) cycles.

REQ-005 P == 0 in blink mode SHALL toggle o_led[i] every cycle.

REQ-006 Off mode (00) SHALL force o_led[i] to 0 and on mode (01) SHALL force o_led[i] to 1, on the clock edge after the mode is applied; in both modes C, T and o_done[i] SHALL be held at 0.

REQ-007 On any cycle where mode[i] differs from M, the following SHALL happen on that edge:
- C and T are cleared to 0.
- o_done[i] is cleared to 0.
- o_led[i] is loaded with 0 for modes 00, 10 and 11, and with 1 for mode 01.
- Counting begins on the following cycle.

REQ-008 Burst mode (11) SHALL behave as blink mode, and additionally:
- Each toggle increments T.
- When the toggle that makes T == 2*BURST occurs, o_led[i] is 0 and C stops.
- o_done[i] is set to 1 on that same edge.
- Both hold until mode[i] changes.

REQ-009 A period write SHALL be accepted when cfg_we = 1 and cfg_ch < N_CH:
- P[cfg_ch] is loaded with cfg_period.
- C[cfg_ch] is cleared to 0 on the same edge.
- o_led, T and o_done of that channel are unchanged.

REQ-010 A period write with cfg_ch >= N_CH SHALL be ignored, with no state change.

REQ-011 When cfg_we and a C == P wrap coincide on the addressed channel, the toggle SHALL occur, and C SHALL be 0 and P SHALL hold the new value after the edge.

REQ-012 A mode change and a period write on the same channel in the same cycle SHALL both take effect: P is updated and REQ-007 applies.

REQ-013 C SHALL never exceed P. The counter is compared for equality only, and every P change clears C.

REQ-014 Channels SHALL be fully independent; activity on one channel SHALL NOT alter the timing of another channel.

REQ-015 Latency SHALL be one cycle from any input to an o_led or o_done change; there is no combinational path from input to output.

Reset
REQ-016 While rst = 1, on each clock edge the block SHALL set:
- every P to DEF_PERIOD;
- C, T and o_done to 0;
- M to 00;
- o_led to 0.

REQ-017 Reset SHALL take priority over cfg_we, mode changes and sync_req.

REQ-018 After rst is released with mode 10 applied, the first toggle SHALL occur when C == P, i.e. P+1 cycles after the mode-change edge.

Configuration
REQ-019 With macro LED_SYNC_EN defined:
- Input port sync_req is present.
- When sync_req = 1, every channel's C is cleared to 0, and o_led is cleared to 0 for channels in mode 10 or 11, all on the same edge.
- Channels with equal P then toggle in phase.
- sync_req takes priority over a coincident wrap.
- A coincident cfg_we still loads P.

REQ-020 Without LED_SYNC_EN, the sync_req port and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset, then mode=all 10, P=DEF_PERIOD left unchanged: o_led[0] rises 100000001 cycles after the mode-change edge and falls 100000001 cycles later.
- cfg write ch1 P=4, mode ch1=10: o_led[1] toggles every 5 cycles, period 10; ch0 timing unaffected.
- ch2 P=0, mode 10: o_led[2] toggles every cycle.
- ch3 P=2, BURST=3, mode 11: exactly 3 high pulses of 3 cycles each; then o_led[3]=0 and o_done[3]=1 held; switching to 00 then 11 restarts the burst.
- ch1 P=9 blinking, write P=3 when C=7: C goes to 0, toggles resume every 4 cycles; a write to cfg_ch=15 with N_CH=4 changes nothing.
- LED_SYNC_EN: ch0 and ch1 both P=5 and out of phase, sync_req pulse: both at 0 then toggle on the same cycles thereafter; rst mid-blink forces o_led=0 on the next edge.

Source files
------------

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: per-channel off/on/blink/burst modes with programmable periods.
// Optional macro LED_SYNC_EN adds the sync_req input that re-phases every channel.
module led_blink_ctrl #(
   parameter int          N_CH       = 4,
   parameter int          CNT_W      = 32,
   parameter int unsigned DEF_PERIOD = 100000000,
   parameter int          BURST      = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2*N_CH-1:0]   mode,
   input  logic                cfg_we,
   input  logic [3:0]          cfg_ch,
   input  logic [CNT_W-1:0]    cfg_period,
   output logic [N_CH-1:0]     o_led,
   output logic [N_CH-1:0]     o_done
`ifdef LED_SYNC_EN
   ,
   input  logic                sync_req
`endif
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_BURST = 2'b11
   } mode_e;

   localparam logic [8:0] TOG_END = 9'(2 * BURST);

   logic [CNT_W-1:0] per_q  [N_CH];
   logic [CNT_W-1:0] cnt_q  [N_CH];
   logic [8:0]       tog_q  [N_CH];
   mode_e            mode_q [N_CH];

   mode_e            mode_ch [N_CH];
   logic [N_CH-1:0]  wr_hit;
   logic [N_CH-1:0]  wrap;
   logic [N_CH-1:0]  changed;
   logic             sync_hit;

`ifdef LED_SYNC_EN
   assign sync_hit = sync_req;
`else
   assign sync_hit = 1'b0;
`endif

   // Writes to a channel index at or above N_CH match no channel and are dropped.
   always_comb begin
      wr_hit  = '0;
      wrap    = '0;
      changed = '0;
      for (int i = 0; i < N_CH; i++) begin
         mode_ch[i] = mode_e'(mode[2*i +: 2]);
         wr_hit[i]  = cfg_we && (cfg_ch == 4'(i));
         wrap[i]    = (cnt_q[i] == per_q[i]);
         changed[i] = (mode_ch[i] != mode_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            per_q[i]  <= CNT_W'(DEF_PERIOD);
            cnt_q[i]  <= '0;
            tog_q[i]  <= '0;
            mode_q[i] <= MODE_OFF;
         end
         o_led  <= '0;
         o_done <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (wr_hit[i]) begin
               per_q[i] <= cfg_period;
            end
            if (changed[i]) begin
               mode_q[i] <= mode_ch[i];
               cnt_q[i]  <= '0;
               tog_q[i]  <= '0;
               o_done[i] <= 1'b0;
               o_led[i]  <= (mode_ch[i] == MODE_ON);
            end else begin
               case (mode_ch[i])
                  MODE_OFF, MODE_ON: begin
                     cnt_q[i]  <= '0;
                     tog_q[i]  <= '0;
                     o_done[i] <= 1'b0;
                     o_led[i]  <= (mode_ch[i] == MODE_ON);
                  end
                  default: begin
                     if (sync_hit) begin
                        cnt_q[i] <= '0;
                        o_led[i] <= 1'b0;
                     end else if (o_done[i]) begin
                        // Finished burst parks with the counter stopped at zero.
                        cnt_q[i] <= '0;
                     end else if (wrap[i]) begin
                        cnt_q[i] <= '0;
                        if (mode_ch[i] == MODE_BURST) begin
                           tog_q[i] <= tog_q[i] + 9'd1;
                           if (tog_q[i] + 9'd1 == TOG_END) begin
                              o_done[i] <= 1'b1;
                              o_led[i]  <= 1'b0;
                           end else begin
                              o_led[i] <= ~o_led[i];
                           end
                        end else begin
                           o_led[i] <= ~o_led[i];
                        end
                     end else begin
                        cnt_q[i] <= wr_hit[i] ? '0 : cnt_q[i] + CNT_W'(1);
                     end
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl: directed sequences, a burst vector table and randomized traffic
// checked against a toggle-counting reference model. Build with LED_SYNC_EN to exercise sync_req.
module tb_led_blink_ctrl;

   localparam int N_CH  = 4;
   localparam int CNT_W = 16;
   localparam int DEF_P = 20;
   localparam int BURST = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [2*N_CH-1:0] mode;
   logic              cfg_we;
   logic [3:0]        cfg_ch;
   logic [CNT_W-1:0]  cfg_period;
   logic              sync_req;
   logic [N_CH-1:0]   o_led;
   logic [N_CH-1:0]   o_done;

   int n_checks = 0;
   int n_errors = 0;

   led_blink_ctrl #(
      .N_CH(N_CH), .CNT_W(CNT_W), .DEF_PERIOD(DEF_P), .BURST(BURST)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mode(mode),
      .cfg_we(cfg_we),
      .cfg_ch(cfg_ch),
      .cfg_period(cfg_period),
      .o_led(o_led),
      .o_done(o_done)
`ifdef LED_SYNC_EN
      ,
      .sync_req(sync_req)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Each channel's output is derived from how many toggles have elapsed since the
   // last restart: whole periods in the edges counted since the last counter clear,
   // plus toggles banked before that clear.
   int              mp    [N_CH];
   logic [1:0]      mm    [N_CH];
   longint          mk    [N_CH];
   longint          mtb   [N_CH];
   logic            mbase [N_CH];
   logic [N_CH-1:0] m_led;
   logic [N_CH-1:0] m_done;

   always @(posedge clk) begin
      for (int i = 0; i < N_CH; i++) begin
         logic [1:0] md;
         logic       wr;
         longint     tog;
         md = mode[2*i +: 2];
         wr = cfg_we && (cfg_ch == 4'(i));
         if (rst) begin
            mp[i] = DEF_P; mm[i] = 2'b00; mk[i] = 0; mtb[i] = 0; mbase[i] = 1'b0;
         end else if (md != mm[i]) begin
            mm[i] = md; mk[i] = 0; mtb[i] = 0; mbase[i] = (md == 2'b01);
            if (wr) mp[i] = int'(cfg_period);
         end else if (md < 2'b10) begin
            mk[i] = 0; mtb[i] = 0; mbase[i] = md[0];
            if (wr) mp[i] = int'(cfg_period);
         end else if (sync_req) begin
            tog = mtb[i] + mk[i] / (mp[i] + 1);
            mtb[i] = tog; mbase[i] = tog[0]; mk[i] = 0;
            if (wr) mp[i] = int'(cfg_period);
         end else begin
            mk[i] = mk[i] + 1;
            if (wr) begin
               mtb[i] = mtb[i] + mk[i] / (mp[i] + 1);
               mk[i] = 0;
               mp[i] = int'(cfg_period);
            end
         end
         tog = mtb[i] + mk[i] / (mp[i] + 1);
         if (mm[i] == 2'b11 && tog >= 2 * BURST) begin
            m_done[i] = 1'b1; m_led[i] = 1'b0;
         end else begin
            m_done[i] = 1'b0;
            m_led[i]  = (mm[i] < 2'b10) ? mm[i][0] : (mbase[i] ^ tog[0]);
         end
      end
   end

   // ---------------- driver / check tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1; mode = '0; cfg_we = 1'b0; sync_req = 1'b0;
      repeat (2) cyc();
      rst = 1'b0;
   endtask

   task automatic cfg_write(input logic [3:0] ch, input logic [CNT_W-1:0] p);
      cfg_we = 1'b1; cfg_ch = ch; cfg_period = p;
      cyc();
      cfg_we = 1'b0;
   endtask

   // ---------------- burst vector table ----------------
   typedef struct {
      logic [2*N_CH-1:0] mode;
      logic [N_CH-1:0]   exp_led;
      logic [N_CH-1:0]   exp_done;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic [2*N_CH-1:0] m, input logic l3, input logic d3);
      vec_t v;
      v.mode = m; v.exp_led = {l3, 3'b000}; v.exp_done = {d3, 3'b000};
      vecs.push_back(v);
   endtask

   // ---------------- scoreboard ----------------
   logic [2*N_CH-1:0] exp_q[$];

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      int n;
      logic e;
      logic [2*N_CH-1:0] exp;

      // ch3 at P=2: high on edges 3-5, 9-11, 15-17, done from edge 18.
      for (int k = 0; k <= 22; k++)
         add_vec(8'hC0, (k >= 3 && k <= 5) || (k >= 9 && k <= 11) || (k >= 15 && k <= 17),
                 k >= 18);
      add_vec(8'h00, 1'b0, 1'b0);
      for (int k = 0; k <= 5; k++)
         add_vec(8'hC0, k >= 3, 1'b0);

      rst = 1'b1; mode = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; sync_req = 1'b0;
      repeat (3) cyc();
      check("reset_led", o_led, 0);
      check("reset_done", o_done, 0);
      rst = 1'b0;

      // Default period: rise and fall DEF_P+1 edges apart.
      mode = 8'b10_10_10_10;
      cyc();
      check("mode_edge_led", o_led, 0);
      n = 0;
      while (o_led[0] == 1'b0 && n < 200) begin cyc(); n++; end
      check("def_first_rise", n, DEF_P + 1);
      n = 0;
      while (o_led[0] == 1'b1 && n < 200) begin cyc(); n++; end
      check("def_fall", n, DEF_P + 1);

      // ch1 P=4, ch2 P=0, ch0 default period, all blinking together.
      reset_dut();
      cfg_write(4'd1, 16'd4);
      cfg_write(4'd2, 16'd0);
      mode = 8'b00_10_10_10;
      cyc();
      check("multi_k0", o_led, 0);
      for (int k = 1; k <= 30; k++) begin
         cyc();
         check("multi_blink", o_led, {1'b0, 1'(k & 1), 1'((k / 5) & 1), 1'((k / 21) & 1)});
      end
      rst = 1'b1;
      cyc();
      check("rst_mid_led", o_led, 0);
      check("rst_mid_done", o_done, 0);
      rst = 1'b0;

      // ch1 P=9, rewritten to 3 while C=7; bad channel write mid-stream.
      reset_dut();
      cfg_write(4'd1, 16'd9);
      mode = 8'b00_00_10_00;
      cyc();
      for (int j = 1; j <= 7; j++) begin
         cyc();
         check("p9_pre", o_led, 0);
      end
      cfg_write(4'd1, 16'd3);
      check("rewrite_edge", o_led, 0);
      for (int j = 9; j <= 26; j++) begin
         cfg_we = (j == 14); cfg_ch = 4'd15; cfg_period = 16'd1;
         cyc();
         check("p3_blink", o_led, {2'b00, 1'(((j - 8) / 4) & 1), 1'b0});
      end
      cfg_we = 1'b0;

      // Burst table on ch3.
      reset_dut();
      cfg_write(4'd3, 16'd2);
      for (int i = 0; i < vecs.size(); i++) begin
         mode = vecs[i].mode;
         cyc();
         check("burst_led", o_led, vecs[i].exp_led);
         check("burst_done", o_done, vecs[i].exp_done);
      end

`ifdef LED_SYNC_EN
      // Two channels with equal period, out of phase, realigned by sync_req.
      reset_dut();
      cfg_write(4'd0, 16'd5);
      cfg_write(4'd1, 16'd5);
      mode = 8'b00_00_00_10;
      repeat (3) cyc();
      mode = 8'b00_00_10_10;
      repeat (6) cyc();
      check("sync_pre_phase", o_led[1:0], 2'b01);
      sync_req = 1'b1;
      cyc();
      sync_req = 1'b0;
      check("sync_edge", o_led[1:0], 2'b00);
      for (int k = 1; k <= 18; k++) begin
         cyc();
         e = 1'((k / 6) & 1);
         check("sync_in_phase", o_led[1:0], {e, e});
      end
`endif

      // Randomized traffic against the model.
      reset_dut();
      for (int c = 0; c < 900; c++) begin
         int r;
         rst = ($urandom_range(0, 249) == 0);
         if ($urandom_range(0, 11) == 0) begin
            r = $urandom_range(0, N_CH - 1);
            mode[2*r +: 2] = 2'($urandom_range(0, 3));
         end
         cfg_we = ($urandom_range(0, 7) == 0);
         r = $urandom_range(0, 6);
         cfg_ch = (r == 6) ? 4'd15 : 4'(r);
         cfg_period = 16'($urandom_range(0, 6));
`ifdef LED_SYNC_EN
         sync_req = ($urandom_range(0, 29) == 0);
`endif
         cyc();
         exp_q.push_back({m_done, m_led});
         exp = exp_q.pop_front();
         check("rand_out", {o_done, o_led}, exp);
      end
      rst = 1'b0; cfg_we = 1'b0; sync_req = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
